// File: rtl/mac_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mac_sequencer
// Brief    : Sequencer for a shared signed N x N MAC computing a TAPS-tap FIR
//            output from an internal delay line and an external registered
//            coefficient ROM. Optional output saturation: MAC_SATURATION_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mac_sequencer #(
    parameter int N    = 24,
    parameter int FRAC = 10,
    parameter int TAPS = 5,
    parameter int AW   = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [N-1:0]  sample_in,
    output logic [AW-1:0] coef_addr,
    input  logic [N-1:0]  coef_data,
    output logic          busy,
    output logic [N-1:0]  result,
    output logic          result_valid,
    input  logic          result_ready,
    output logic          overflow
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_MAC   = 3'd2,
        S_SAT   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [AW-1:0] c_last_idx = AW'(TAPS - 1);

    state_t                  r_state;
    logic signed [N-1:0]     r_x [TAPS];
    logic signed [2*N-1:0]   r_acc;
    logic [AW-1:0]           r_idx;

    logic signed [2*N-1:0]   w_coef_ext;
    logic signed [2*N-1:0]   w_x_ext;
    logic signed [2*N-1:0]   w_prod;

    // Operands are sign-extended to the accumulator width so the product is the full signed 2N-bit value.
    assign w_coef_ext = {{N{coef_data[N-1]}}, coef_data};
    assign w_x_ext    = {{N{r_x[r_idx][N-1]}}, r_x[r_idx]};
    assign w_prod     = w_coef_ext * w_x_ext;

`ifdef MAC_SATURATION_EN
    logic signed [2*N-1:0]   w_scaled;
    logic [N:0]              w_hi;
    logic                    w_ovf;
    logic [N-1:0]            w_sat;

    // The scaled value fits in N bits only when every bit above the result sign bit matches it.
    assign w_scaled = r_acc >>> FRAC;
    assign w_hi     = w_scaled[2*N-1:N-1];
    assign w_ovf    = !((&w_hi) || (~|w_hi));
    assign w_sat    = !w_ovf     ? w_scaled[N-1:0] :
                      w_hi[N]    ? {1'b1, {(N-1){1'b0}}} :
                                   {1'b0, {(N-1){1'b1}}};
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            for (int k = 0; k < TAPS; k++) begin
                r_x[k] <= '0;
            end
            r_acc        <= '0;
            r_idx        <= '0;
            coef_addr    <= '0;
            busy         <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        for (int k = TAPS - 1; k > 0; k--) begin
                            r_x[k] <= r_x[k-1];
                        end
                        r_x[0]    <= $signed(sample_in);
                        r_acc     <= '0;
                        coef_addr <= '0;
                        busy      <= 1'b1;
                        r_state   <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    coef_addr <= AW'(1);
                    r_idx     <= '0;
                    r_state   <= S_MAC;
                end
                S_MAC: begin
                    // The ROM is one cycle behind, so the address runs two ahead of the tap in use.
                    r_acc     <= r_acc + w_prod;
                    coef_addr <= r_idx + AW'(2);
                    r_idx     <= r_idx + AW'(1);
                    if (r_idx == c_last_idx) begin
                        r_state <= S_SAT;
                    end
                end
                S_SAT: begin
`ifdef MAC_SATURATION_EN
                    result   <= w_sat;
                    overflow <= w_ovf;
`else
                    result   <= r_acc[FRAC +: N];
                    overflow <= 1'b0;
`endif
                    result_valid <= 1'b1;
                    r_state      <= S_DONE;
                end
                S_DONE: begin
                    if (result_ready) begin
                        result_valid <= 1'b0;
                        busy         <= 1'b0;
                        r_state      <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mac_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mac_sequencer
// Brief    : Directed self-checking bench for mac_sequencer with a registered
//            coefficient ROM model (honours MAC_SATURATION_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mac_sequencer;
    localparam int N    = 24;
    localparam int FRAC = 10;
    localparam int TAPS = 5;
    localparam int AW   = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [N-1:0]  sample_in = '0;
    logic [AW-1:0] coef_addr;
    logic [N-1:0]  coef_data = '0;
    logic          busy;
    logic [N-1:0]  result;
    logic          result_valid;
    logic          result_ready = 1'b0;
    logic          overflow;

    logic [N-1:0]  rom [8];
    int            n_checks = 0;
    int            n_pass   = 0;

    mac_sequencer #(.N(N), .FRAC(FRAC), .TAPS(TAPS), .AW(AW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .sample_in    (sample_in),
        .coef_addr    (coef_addr),
        .coef_data    (coef_data),
        .busy         (busy),
        .result       (result),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) coef_data <= rom[coef_addr];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n        = 1'b0;
        start        = 1'b0;
        result_ready = 1'b0;
        sample_in    = '0;
        tick;
        tick;
        rst_n = 1'b1;
    endtask

    task automatic set_rom(input logic [N-1:0] c0, input logic [N-1:0] c1, input logic [N-1:0] c2,
                           input logic [N-1:0] c3, input logic [N-1:0] c4);
        for (int i = 0; i < 8; i++) rom[i] = '0;
        rom[0] = c0; rom[1] = c1; rom[2] = c2; rom[3] = c3; rom[4] = c4;
    endtask

    task automatic run_sample(input logic [N-1:0] s, output logic [N-1:0] res, output logic ov);
        int cyc;
        start     = 1'b1;
        sample_in = s;
        tick;
        start = 1'b0;
        cyc   = 0;
        while (!result_valid && cyc < 20) begin
            tick;
            cyc++;
        end
        if (!result_valid) begin
            n_checks++;
            $display("FAIL run_sample_timeout: result_valid=%0b required 1", result_valid);
        end
        res = result;
        ov  = overflow;
        result_ready = 1'b1;
        tick;
        result_ready = 1'b0;
    endtask

    task automatic test_reset;
        do_reset;
        n_checks++; if (coef_addr !== 3'd0) $display("FAIL reset_coef_addr: got %0d want 0", coef_addr); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0b want 0", busy); else n_pass++;
        n_checks++; if (result !== 24'h0) $display("FAIL reset_result: got %h want 000000", result); else n_pass++;
        n_checks++; if (result_valid !== 1'b0) $display("FAIL reset_valid: got %0b want 0", result_valid); else n_pass++;
        n_checks++; if (overflow !== 1'b0) $display("FAIL reset_overflow: got %0b want 0", overflow); else n_pass++;
    endtask

    task automatic test_impulse;
        logic [N-1:0] r;
        logic         o;
        int exp_r [6] = '{1024, 512, 256, 128, 64, 0};
        set_rom(24'd1024, 24'd512, 24'd256, 24'd128, 24'd64);
        do_reset;
        for (int i = 0; i < 6; i++) begin
            run_sample((i == 0) ? 24'd1024 : 24'd0, r, o);
            n_checks++; if (r !== N'(exp_r[i])) $display("FAIL impulse_result[%0d]: got %0d want %0d", i, r, exp_r[i]); else n_pass++;
            n_checks++; if (o !== 1'b0) $display("FAIL impulse_overflow[%0d]: got %0b want 0", i, o); else n_pass++;
        end
    endtask

    task automatic test_latency;
        set_rom(24'd1024, 24'd512, 24'd256, 24'd128, 24'd64);
        do_reset;
        start     = 1'b1;
        sample_in = 24'd1024;
        tick;
        start = 1'b0;
        for (int i = 0; i <= 7; i++) begin
            if (i < 5) begin
                n_checks++; if (coef_addr !== AW'(i)) $display("FAIL latency_coef_addr[%0d]: got %0d want %0d", i, coef_addr, i); else n_pass++;
            end
            n_checks++; if (result_valid !== (i == 7)) $display("FAIL latency_valid[E+%0d]: got %0b want %0b", i, result_valid, (i == 7)); else n_pass++;
            n_checks++; if (busy !== 1'b1) $display("FAIL latency_busy[E+%0d]: got %0b want 1", i, busy); else n_pass++;
            if (i < 7) tick;
        end
        n_checks++; if (result !== 24'd1024) $display("FAIL latency_result: got %0d want 1024", result); else n_pass++;
        result_ready = 1'b1;
        tick;
        result_ready = 1'b0;
        n_checks++; if (busy !== 1'b0 || result_valid !== 1'b0) $display("FAIL latency_release: busy=%0b valid=%0b want 0 0", busy, result_valid); else n_pass++;
        n_checks++; if (result !== 24'd1024) $display("FAIL latency_result_kept: got %0d want 1024", result); else n_pass++;
    endtask

    task automatic test_saturation;
        logic [N-1:0] r, exp_pos, exp_neg;
        logic         o, exp_ovf;
`ifdef MAC_SATURATION_EN
        exp_pos = 24'h7FFFFF; exp_neg = 24'h800000; exp_ovf = 1'b1;
`else
        exp_pos = 24'h000000; exp_neg = 24'h000000; exp_ovf = 1'b0;
`endif
        set_rom(24'h400000, 24'h400000, 24'h400000, 24'h400000, 24'h400000);
        do_reset;
        r = '0; o = 1'b0;
        for (int i = 0; i < 5; i++) run_sample(24'h400000, r, o);
        n_checks++; if (r !== exp_pos) $display("FAIL sat_pos_result: got %h want %h", r, exp_pos); else n_pass++;
        n_checks++; if (o !== exp_ovf) $display("FAIL sat_pos_overflow: got %0b want %0b", o, exp_ovf); else n_pass++;
        for (int i = 0; i < 5; i++) run_sample(24'hC00000, r, o);
        n_checks++; if (r !== exp_neg) $display("FAIL sat_neg_result: got %h want %h", r, exp_neg); else n_pass++;
        n_checks++; if (o !== exp_ovf) $display("FAIL sat_neg_overflow: got %0b want %0b", o, exp_ovf); else n_pass++;
    endtask

    // Only tap 0 is non-zero (2**22), so result = x[0] * 4096 before clipping.
    task automatic test_sat_boundary;
        logic [N-1:0] r;
        logic         o;
        logic [N-1:0] smp [4] = '{24'h0007FF, 24'h000801, 24'hFFF800, 24'hFFF7FF};
        logic [N-1:0] exp_r [4];
        logic         exp_o [4];
`ifdef MAC_SATURATION_EN
        exp_r = '{24'h7FF000, 24'h7FFFFF, 24'h800000, 24'h800000};
        exp_o = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
        exp_r = '{24'h7FF000, 24'h801000, 24'h800000, 24'h7FF000};
        exp_o = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
        set_rom(24'h400000, 24'h0, 24'h0, 24'h0, 24'h0);
        do_reset;
        for (int i = 0; i < 4; i++) begin
            run_sample(smp[i], r, o);
            n_checks++; if (r !== exp_r[i]) $display("FAIL bound_result[%0d]: got %h want %h", i, r, exp_r[i]); else n_pass++;
            n_checks++; if (o !== exp_o[i]) $display("FAIL bound_overflow[%0d]: got %0b want %0b", i, o, exp_o[i]); else n_pass++;
        end
    endtask

    task automatic test_backpressure;
        logic [N-1:0] r;
        logic         o;
        int           cyc;
        set_rom(24'd1024, 24'd512, 24'd256, 24'd128, 24'd64);
        do_reset;
        start     = 1'b1;
        sample_in = 24'd1024;
        tick;
        start = 1'b0;
        cyc   = 0;
        while (!result_valid && cyc < 20) begin
            tick;
            cyc++;
        end
        n_checks++; if (result_valid !== 1'b1) $display("FAIL bp_first_valid: got %0b want 1", result_valid); else n_pass++;
        for (int i = 0; i < 10; i++) begin
            start     = 1'b1;
            sample_in = N'(i * 100 + 7);
            tick;
            n_checks++; if (result !== 24'd1024 || result_valid !== 1'b1 || busy !== 1'b1)
                $display("FAIL bp_hold[%0d]: result=%0d valid=%0b busy=%0b want 1024 1 1", i, result, result_valid, busy);
            else n_pass++;
        end
        start = 1'b0;
        result_ready = 1'b1;
        tick;
        result_ready = 1'b0;
        n_checks++; if (result_valid !== 1'b0) $display("FAIL bp_taken: valid=%0b want 0", result_valid); else n_pass++;
        run_sample(24'd0, r, o);
        n_checks++; if (r !== 24'd512) $display("FAIL bp_delay_line: got %0d want 512", r); else n_pass++;
    endtask

    task automatic test_reset_mid_mac;
        logic [N-1:0] r;
        logic         o;
        set_rom(24'd1024, 24'd512, 24'd256, 24'd128, 24'd64);
        do_reset;
        run_sample(24'd1024, r, o);
        start     = 1'b1;
        sample_in = 24'd2048;
        tick;
        start = 1'b0;
        tick;
        tick;
        tick;
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        n_checks++; if (busy !== 1'b0 || result_valid !== 1'b0 || overflow !== 1'b0)
            $display("FAIL midrst_flags: busy=%0b valid=%0b ovf=%0b want 0 0 0", busy, result_valid, overflow);
        else n_pass++;
        n_checks++; if (result !== 24'h0 || coef_addr !== 3'd0)
            $display("FAIL midrst_data: result=%h addr=%0d want 000000 0", result, coef_addr);
        else n_pass++;
        tick;
        tick;
        n_checks++; if (result_valid !== 1'b0 || busy !== 1'b0) $display("FAIL midrst_idle: valid=%0b busy=%0b want 0 0", result_valid, busy); else n_pass++;
        run_sample(24'd1024, r, o);
        n_checks++; if (r !== 24'd1024) $display("FAIL midrst_first_sample: got %0d want 1024", r); else n_pass++;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) rom[i] = '0;
        test_reset;
        test_impulse;
        test_latency;
        test_saturation;
        test_sat_boundary;
        test_backpressure;
        test_reset_mid_mac;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
